tx_serializer: RTL and testbench

TX_SERIALIZER -- requirements
Module: tx_serializer

---
 rtl/usb_utmi_pkg.sv | 15 +
 rtl/nrzi_encoder.sv | 23 ++
 rtl/tx_serializer.sv | 150 +++++++++++++++
 tb/tb_tx_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI transmit definitions: serializer states and line-coding constants.
package usb_utmi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA,
      EOP
   } tx_state_e;

   localparam logic [7:0]  SYNC_PAT     = 8'h80;
   localparam int unsigned STUFF_LIM    = 6;
   localparam int unsigned EOP_SE0_BITS = 2;

endpackage

// File: rtl/nrzi_encoder.sv
// NRZI line register: a 0 bit toggles the line, a 1 bit holds it; init forces J.
module nrzi_encoder (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_strobe,
   input  logic i_bit,
   input  logic i_init_j,
   output logic o_nrzi
);

   logic r_nrzi;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_init_j) begin
         r_nrzi <= 1'b1;
      end else if (i_strobe && !i_bit) begin
         r_nrzi <= ~r_nrzi;
      end
   end

   assign o_nrzi = r_nrzi;

endmodule

// File: rtl/tx_serializer.sv
// UTMI transmit serializer: SYNC, bit-stuffed LSB-first bytes and EOP onto an NRZI line.
module tx_serializer #(
   parameter logic [7:0]  SYNC_PAT  = usb_utmi_pkg::SYNC_PAT,
   parameter int unsigned STUFF_LIM = usb_utmi_pkg::STUFF_LIM
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       shift_en,
   input  logic       TX_valid,
   input  logic [7:0] data_i,
   output logic       TX_ready,
   output logic       NRZI_I,
   output logic       SE0_o,
   output logic       tx_en
);

   import usb_utmi_pkg::*;

   localparam logic [2:0] L_STUFF_LIM = 3'(STUFF_LIM);
   localparam logic [2:0] L_SE0_BITS  = 3'(EOP_SE0_BITS);

   tx_state_e  r_state;
   logic [7:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic [2:0] r_ones;
   logic       r_tx_ready;
   logic       r_se0;
   logic       r_tx_en;

   logic       w_stuff;
   logic       w_strobe;
   logic       w_bit;
   logic       w_init_j;
   logic       w_nrzi;

   assign w_stuff = (r_ones == L_STUFF_LIM);

   // Line-bit selection for the encoder; the TX_ready cycle never emits.
   always_comb begin
      w_strobe = 1'b0;
      w_bit    = 1'b1;
      w_init_j = 1'b0;
      unique case (r_state)
         IDLE: w_init_j = TX_valid;
         SYNC, DATA: begin
            if (shift_en && !r_tx_ready) begin
               w_strobe = 1'b1;
               if (w_stuff) begin
                  w_bit = 1'b0;
               end else if (r_state == SYNC) begin
                  w_bit = SYNC_PAT[r_bit_cnt];
               end else begin
                  w_bit = r_shift[0];
               end
            end
         end
         EOP: begin
            if (shift_en) begin
               if (w_stuff) begin
                  w_strobe = 1'b1;
                  w_bit    = 1'b0;
               end else begin
                  w_init_j = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_shift    <= 8'h00;
         r_bit_cnt  <= 3'd0;
         r_ones     <= 3'd0;
         r_tx_ready <= 1'b0;
         r_se0      <= 1'b0;
         r_tx_en    <= 1'b0;
      end else begin
         r_tx_ready <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (TX_valid) begin
                  r_state   <= SYNC;
                  r_tx_en   <= 1'b1;
                  r_bit_cnt <= 3'd0;
                  r_ones    <= 3'd0;
               end
            end
            SYNC, DATA: begin
               if (r_tx_ready) begin
                  r_bit_cnt <= 3'd0;
                  if (TX_valid) begin
                     r_shift <= data_i;
                     r_state <= DATA;
                  end else begin
                     r_state <= EOP;
                  end
               end else if (shift_en) begin
                  if (w_stuff) begin
                     r_ones <= 3'd0;
                  end else begin
                     r_ones    <= w_bit ? r_ones + 3'd1 : 3'd0;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_state == DATA) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                     end
                     if (r_bit_cnt == 3'd7) begin
                        r_tx_ready <= 1'b1;
                     end
                  end
               end
            end
            EOP: begin
               // A stuff bit owed by the last byte goes out before SE0.
               if (shift_en) begin
                  if (w_stuff) begin
                     r_ones <= 3'd0;
                  end else if (r_bit_cnt < L_SE0_BITS) begin
                     r_se0     <= 1'b1;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end else if (r_bit_cnt == L_SE0_BITS) begin
                     r_se0     <= 1'b0;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end else begin
                     r_state   <= IDLE;
                     r_tx_en   <= 1'b0;
                     r_bit_cnt <= 3'd0;
                  end
               end
            end
         endcase
      end
   end

   nrzi_encoder u_nrzi (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_strobe (w_strobe),
      .i_bit    (w_bit),
      .i_init_j (w_init_j),
      .o_nrzi   (w_nrzi)
   );

   assign TX_ready = r_tx_ready;
   assign NRZI_I   = w_nrzi;
   assign SE0_o    = r_se0;
   assign tx_en    = r_tx_en;

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: packet-level line model with per-cycle output comparison.
module tb_tx_serializer;

   localparam logic [7:0]  SYNC_PAT  = 8'h80;
   localparam int unsigned STUFF_LIM = 6;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       shift_en = 1'b0;
   logic       TX_valid = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       TX_ready;
   logic       NRZI_I;
   logic       SE0_o;
   logic       tx_en;

   tx_serializer #(
      .SYNC_PAT  (SYNC_PAT),
      .STUFF_LIM (STUFF_LIM)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .shift_en (shift_en),
      .TX_valid (TX_valid),
      .data_i   (data_i),
      .TX_ready (TX_ready),
      .NRZI_I   (NRZI_I),
      .SE0_o    (SE0_o),
      .tx_en    (tx_en)
   );

   always #5 CLK = ~CLK;

   int n_checks   = 0;
   int n_errors   = 0;
   int ready_seen = 0;
   bit check_en   = 1'b0;

   // Packet bytes and the expected per-bit-time line symbols derived from them.
   logic [7:0] pkt [8];
   logic       m_lvl [64];
   logic       m_se0 [64];
   logic       m_rdy [64];
   logic       m_end [64];
   int         m_n;

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add_sym(input logic l, input logic s, input logic r, input logic e);
      m_lvl[m_n] = l;
      m_se0[m_n] = s;
      m_rdy[m_n] = r;
      m_end[m_n] = e;
      m_n++;
   endfunction

   // Bit stream -> stuffing -> NRZI levels, then SE0, SE0, J and the return to idle.
   function automatic void build_model(input int n);
      bit         stream [$];
      bit         ends [$];
      logic [7:0] sp;
      int         ones;
      logic       lvl;
      sp   = SYNC_PAT;
      ones = 0;
      lvl  = 1'b1;
      m_n  = 0;
      for (int i = 0; i < 8; i++) begin
         stream.push_back(sp[i]);
         ends.push_back(i == 7);
      end
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 8; i++) begin
            stream.push_back(pkt[k][i]);
            ends.push_back(i == 7);
         end
      end
      foreach (stream[j]) begin
         if (ones == int'(STUFF_LIM)) begin
            lvl  = ~lvl;
            ones = 0;
            add_sym(lvl, 1'b0, 1'b0, 1'b0);
         end
         if (stream[j]) begin
            ones++;
         end else begin
            lvl  = ~lvl;
            ones = 0;
         end
         add_sym(lvl, 1'b0, ends[j], 1'b0);
      end
      if (ones == int'(STUFF_LIM)) begin
         lvl = ~lvl;
         add_sym(lvl, 1'b0, 1'b0, 1'b0);
      end
      add_sym(1'b1, 1'b1, 1'b0, 1'b0);
      add_sym(1'b1, 1'b1, 1'b0, 1'b0);
      add_sym(1'b1, 1'b0, 1'b0, 1'b0);
      add_sym(1'b1, 1'b0, 1'b0, 1'b1);
   endfunction

   // One clock: drive at negedge, compare just after the posedge.
   task automatic step(input logic rst, input logic se, input logic tv, input logic [7:0] d,
                       input logic e_nrzi, input logic e_se0, input logic e_txen,
                       input logic e_rdy);
      @(negedge CLK);
      RST      = rst;
      shift_en = se;
      TX_valid = tv;
      data_i   = d;
      @(posedge CLK);
      #1;
      if (check_en) begin
         chk("NRZI_I", NRZI_I, e_nrzi);
         chk("SE0_o", SE0_o, e_se0);
         chk("tx_en", tx_en, e_txen);
         chk("TX_ready", TX_ready, e_rdy);
         if (TX_ready === 1'b1) ready_seen++;
      end
   endtask

   task automatic gap(input int k);
      for (int i = 0; i < k; i++) begin
         step(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // p = cycles per bit time, h = TX_valid level outside TX_ready cycles,
   // abort_at = symbol index after which RST is pulsed (-1 for none).
   task automatic run_packet(input int n, input int p, input logic h, input int abort_at);
      int         nb;
      logic       tv;
      logic [7:0] d;
      logic       hl;
      logic       hs;
      nb = 0;
      build_model(n);
      step(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
      for (int s = 0; s < m_n; s++) begin
         hl = (s > 0) ? m_lvl[s-1] : 1'b1;
         hs = (s > 0) ? m_se0[s-1] : 1'b0;
         for (int w = 0; w < p - 1; w++) begin
            tv = h;
            d  = 8'($urandom);
            if (w == 0 && s > 0 && m_rdy[s-1]) begin
               tv = (nb < n);
               if (nb < n) begin
                  d = pkt[nb];
                  nb++;
               end
            end
            step(1'b0, 1'b0, tv, d, hl, hs, 1'b1, 1'b0);
         end
         step(1'b0, 1'b1, h, 8'($urandom), m_lvl[s], m_se0[s], ~m_end[s], m_rdy[s]);
         if (s == abort_at) begin
            step(1'b1, 1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
            return;
         end
      end
   endtask

   initial begin
      int         base;
      logic [7:0] v8;
      logic [9:0] v10;

      // Reset, including RST winning over TX_valid and shift_en.
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check_en = 1'b1;
      step(1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      gap(2);

      // Single 0x00 byte: KJKJKJKK then 8 toggles.
      pkt[0] = 8'h00;
      build_model(1);
      chk_int("model_len_00", m_n, 20);
      for (int i = 0; i < 8; i++) v8[i] = m_lvl[i];
      chk_int("model_sync_line", int'(v8), 32'h2A);
      for (int i = 0; i < 8; i++) v8[i] = m_lvl[8 + i];
      chk_int("model_00_line", int'(v8), 32'h55);
      base = ready_seen;
      run_packet(1, 2, 1'b0, -1);
      chk_int("ready_pulses_00", ready_seen - base, 2);
      gap(3);

      // 0xFF: the SYNC tail one plus five data ones force a stuff toggle.
      pkt[0] = 8'hFF;
      build_model(1);
      chk_int("model_len_ff", m_n, 21);
      for (int i = 0; i < 10; i++) v10[i] = m_lvl[7 + i];
      chk_int("model_ff_line", int'(v10), 32'h3C0);
      run_packet(1, 3, 1'b0, -1);
      gap(3);

      // 0x7E then 0x3F back-to-back.
      pkt[0] = 8'h7E;
      pkt[1] = 8'h3F;
      build_model(2);
      chk_int("model_len_7e3f", m_n, 30);
      run_packet(2, 2, 1'b0, -1);
      gap(3);

      // Last byte 0xFC owes a stuff bit before SE0; TX_valid held high through EOP,
      // so the next packet starts on the cycle after IDLE is reached.
      pkt[0] = 8'hA5;
      pkt[1] = 8'hFC;
      build_model(2);
      chk_int("model_len_fc", m_n, 29);
      chk("model_fc_stuff", m_lvl[24], ~m_lvl[23]);
      chk("model_fc_se0", m_se0[25], 1'b1);
      run_packet(2, 2, 1'b1, -1);
      pkt[0] = 8'h00;
      run_packet(1, 2, 1'b0, -1);
      gap(3);

      // Reset mid-DATA with a slow bit strobe, then a clean restart.
      pkt[0] = 8'h3C;
      pkt[1] = 8'h55;
      run_packet(2, 4, 1'b0, 12);
      gap(3);
      pkt[0] = 8'h81;
      run_packet(1, 2, 1'b0, -1);
      gap(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
